sram_ctrl: RTL
==============

# sram_ctrl

Sequencing controller sitting directly upstream of the battleship 256x32 asynchronous SRAM. It accepts single-word read/write requests from game logic over a synchronous req/ready handshake. It then drives the SRAM's address, active-low write-enable and output-enable, and bidirectional 32-bit data bus in the step order the SRAM requires. Read data is returned with a one-cycle valid strobe, and write completion is signalled the same way.

## Interface
- RD_WAIT, 1, cycles the SRAM output is enabled before read data is captured (legal 1..15)
- WE_CYCLES, 1, cycles mem_we is held low per write (legal 1..15)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  1  request strobe; accepted on a rising edge where req=1 and ready=1
- wr  input  1  1 = write, 0 = read; sampled with req
- addr  input  8  word address; sampled with req
- wdata  input  32  write data; sampled with req
- ready  output  1  high only in IDLE; controller can accept a request
- rdata  output  32  captured read word; holds until the next read capture
- rvalid  output  1  one-cycle pulse: rdata has just been updated
- wdone  output  1  one-cycle pulse: write sequence complete
- mem_addrs  output  8  SRAM address
- mem_we  output  1  SRAM write enable, active low
- mem_oe  output  1  SRAM output enable, active low
- mem_data  inout  32  SRAM data bus; driven only during write states, else 32'bz

## Operation
- All memory-side outputs and the bus drive-enable are registered. No combinational path runs from req/addr/wdata to mem_*.
- On acceptance, latch wr, addr and wdata into internal registers. Inputs are ignored while ready=0.
- FSM states: IDLE, RD_ADDR, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD. A 4-bit counter times RD_WAIT and WR_PULSE.
- IDLE: mem_we=1, mem_oe=1, bus released, ready=1, mem_addrs holds its last value.
- Read path:
  - IDLE -> RD_ADDR: mem_addrs=addr, mem_oe=0, mem_we=1.
  - RD_ADDR -> RD_WAIT for RD_WAIT cycles.
  - On the edge ending the last RD_WAIT cycle: capture mem_data into rdata, go to IDLE with mem_oe=1, and pulse rvalid in that first IDLE cycle.
- Write path:
  - IDLE -> WR_SETUP: mem_addrs=addr, drive mem_data=wdata, mem_we=1, mem_oe=1.
  - WR_SETUP -> WR_PULSE: mem_we=0 for WE_CYCLES cycles.
  - WR_PULSE -> WR_HOLD: mem_we=1, addr and data still driven.
  - WR_HOLD -> IDLE: release the bus and pulse wdone.
- Invariants:
  - mem_addrs and mem_data never change while mem_we=0.
  - The controller never drives mem_data while mem_oe=0.
  - mem_oe=0 and mem_we=0 never occur together.
- Back-to-back: a request may be accepted in the same IDLE cycle that carries rvalid or wdone.
- Reset (async, at any point, including mid-write):
  - State=IDLE; mem_we=1, mem_oe=1 and the bus released immediately.
  - mem_addrs=0, rdata=0, rvalid=0, wdone=0, ready=1 once reset is deasserted.
  - Contents of a word whose write was aborted are undefined.

## Timing
- Acceptance edge = edge 0.
- Read: mem_oe low cycles 1..1+RD_WAIT; rvalid high in cycle 2+RD_WAIT (cycle 3 at default); ready high in the same cycle.
- Write: WR_SETUP is cycle 1; mem_we low cycles 2..1+WE_CYCLES; WR_HOLD is cycle 2+WE_CYCLES; wdone and ready high in cycle 3+WE_CYCLES (cycle 4 at default).
- Bus turnaround: at least one cycle with mem_oe=1 and the bus released separates any read-enable period from any write drive. This is guaranteed because IDLE always occupies at least one cycle.
- Throughput at defaults: one read per 3 cycles, one write per 4 cycles.

## Test plan
- Reset: assert reset mid-simulation -> immediately mem_we=1, mem_oe=1, mem_data=z, rdata=0, rvalid=0, wdone=0, mem_addrs=0; after release, ready=1.
- Write then read, defaults: write 32'hDEADBEEF to 8'h3A -> mem_we low exactly 1 cycle with addr 8'h3A and data stable; wdone in cycle 4. Then read 8'h3A -> rvalid in cycle 3 with rdata=32'hDEADBEEF.
- Address extremes: write 32'h00000001 to 8'h00 and 32'hFFFFFFFF to 8'hFF, read both -> each returns its own value, no aliasing.
- Busy handling: hold req=1 continuously with alternating write/read -> a new request is accepted only when ready=1, and wdata/addr changes during busy cycles have no effect.
- Reset mid-write: assert reset during WR_PULSE with WE_CYCLES=4 -> mem_we rises and the bus releases in the same timestep; after release, a read of an untouched address returns its prior value.
- Parameter sweep: RD_WAIT=3, WE_CYCLES=2 -> rvalid in cycle 5, mem_we low for 2 cycles, wdone in cycle 5. A continuous monitor flags any cycle with mem_oe=0 while the controller drives the bus, and any mem_addrs or mem_data change while mem_we=0.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences single-word reads and writes onto a 256x32 asynchronous SRAM.
// Every memory-side output and the bus drive-enable come straight from a flop.
module sram_ctrl #(
    parameter int unsigned RD_WAIT   = 1,
    parameter int unsigned WE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_wdone,
    output logic [7:0]  o_mem_addrs,
    output logic        o_mem_we,
    output logic        o_mem_oe,
    inout  wire  [31:0] io_mem_data
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdWait,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);
    localparam logic [3:0] WeLoad = 4'(WE_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_wdata;
    logic [7:0]  r_mem_addrs;
    logic        r_mem_we;
    logic        r_mem_oe;
    logic        r_drive;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_wdone;

    logic        w_accept;
    logic        w_we_next;
    logic        w_oe_next;
    logic        w_drive_next;
    logic        w_capture;
    logic        w_wdone_next;

    assign o_ready     = (r_state == StIdle);
    assign w_accept    = o_ready && i_req;
    assign o_rdata     = r_rdata;
    assign o_rvalid    = r_rvalid;
    assign o_wdone     = r_wdone;
    assign o_mem_addrs = r_mem_addrs;
    assign o_mem_we    = r_mem_we;
    assign o_mem_oe    = r_mem_oe;
    assign io_mem_data = r_drive ? r_wdata : 32'bz;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The counter is loaded on entry to a timed state and counts down to zero.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_state_next = i_wr ? StWrSetup : StRdAddr;
                end
            end
            StRdAddr: begin
                w_state_next = StRdWait;
                w_cnt_next   = RdLoad;
            end
            StRdWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            StWrSetup: begin
                w_state_next = StWrPulse;
                w_cnt_next   = WeLoad;
            end
            StWrPulse: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = StWrHold;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            StWrHold: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Memory strobes are decoded from the next state so the flops switch with the state.
    always_comb begin
        w_oe_next    = !((w_state_next == StRdAddr) || (w_state_next == StRdWait));
        w_we_next    = (w_state_next != StWrPulse);
        w_drive_next = (w_state_next == StWrSetup) || (w_state_next == StWrPulse) ||
                       (w_state_next == StWrHold);
        w_capture    = (r_state == StRdWait) && (r_cnt == 4'd0);
        w_wdone_next = (r_state == StWrHold);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wdata     <= 32'd0;
            r_mem_addrs <= 8'd0;
            r_mem_we    <= 1'b1;
            r_mem_oe    <= 1'b1;
            r_drive     <= 1'b0;
            r_rdata     <= 32'd0;
            r_rvalid    <= 1'b0;
            r_wdone     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem_addrs <= i_addr;
                r_wdata     <= i_wdata;
            end
            if (w_capture) begin
                r_rdata <= io_mem_data;
            end
            r_mem_we <= w_we_next;
            r_mem_oe <= w_oe_next;
            r_drive  <= w_drive_next;
            r_rvalid <= w_capture;
            r_wdone  <= w_wdone_next;
        end
    end

endmodule
